// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle FSM sequencing fetch/decode/execute/memory/writeback for the MIPS datapath
//
// Optional feature: define MCU_JUMP_EN to decode opcode 000010 (j) into the JUMP state.
// Without it, j is reported as an illegal opcode.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   opcode     in   IR[31:26]
//   memReady   in   memory completes the current access this cycle
//   pcWrite    out  unconditional PC load
//   branch     out  conditional PC load (ANDed with ALU zero outside)
//   iorD       out  memory address source (0 = PC, 1 = ALUOut)
//   memRead    out  memory read request
//   memWrite   out  memory write request
//   irWrite    out  instruction register load
//   regDst     out  register write destination (1 = rd, 0 = rt)
//   memToReg   out  writeback source (1 = MDR, 0 = ALUOut)
//   regWrite   out  register file write enable
//   aluSrcA    out  ALU A (0 = PC, 1 = reg A)
//   aluSrcB    out  ALU B (00 = reg B, 01 = 4, 10 = imm, 11 = imm << 2)
//   aluOp      out  ALU class (00 add, 01 sub, 10 funct)
//   pcSrc      out  PC source (00 ALU, 01 ALUOut, 10 jump target)
//   illegalOp  out  pulse on unsupported opcode in DECODE
//   memTimeout out  pulse when a memory wait is aborted
//   state      out  current FSM state (debug)
module multicycle_control_unit #(
    parameter int WAIT_TIMEOUT = 15,
    parameter int ALUOP_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               branch,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regDst,
    output logic               memToReg,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [ALUOP_W-1:0] aluOp,
    output logic [1:0]         pcSrc,
    output logic               illegalOp,
    output logic               memTimeout,
    output logic [3:0]         state
);
    // A zero timeout still needs a one-bit counter so the declarations stay legal.
    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIMEOUT);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = '0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    logic [3:0]       nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             waitState;
    logic             timeoutHit;
    logic             decodeLegal;

    always_comb begin
        waitState  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
        // memReady in the same cycle as an expired count wins, so it masks the abort.
        timeoutHit = (WAIT_TIMEOUT > 0) && waitState && !memReady && (waitCnt == CNT_MAX);
`ifdef MCU_JUMP_EN
        decodeLegal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R)
                   || (opcode == OP_BEQ) || (opcode == OP_J);
`else
        decodeLegal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R)
                   || (opcode == OP_BEQ);
`endif
    end

    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:  nextState = memReady ? DECODE : FETCH;
            DECODE: nextState = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                                (opcode == OP_R)   ? EXEC   :
                                (opcode == OP_BEQ) ? BRANCH :
`ifdef MCU_JUMP_EN
                                (opcode == OP_J)   ? JUMP   :
`endif
                                FETCH;
            // IR is held through the instruction, so opcode is still valid here.
            MEMADR: nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  nextState = memReady ? MEMWB : (timeoutHit ? FETCH : MEMRD);
            MEMWB:  nextState = FETCH;
            MEMWR:  nextState = (memReady || timeoutHit) ? FETCH : MEMWR;
            EXEC:   nextState = ALUWB;
            ALUWB:  nextState = FETCH;
            BRANCH: nextState = FETCH;
`ifdef MCU_JUMP_EN
            JUMP:   nextState = FETCH;
`endif
            default: nextState = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            if (!waitState || memReady || timeoutHit || nextState != state)
                waitCnt <= '0;
            else if (waitCnt != CNT_MAX)
                waitCnt <= waitCnt + 1'b1;
        end
    end

    always_comb begin
        pcWrite    = 1'b0;
        branch     = 1'b0;
        iorD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluOp      = ALU_ADD;
        pcSrc      = 2'b00;
        illegalOp  = (state == DECODE) && !decodeLegal;
        memTimeout = timeoutHit;
        case (state)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            DECODE: aluSrcB = 2'b11;
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            BRANCH: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_SUB;
                pcSrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MCU_JUMP_EN
            JUMP: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench driving directed instruction sequences through the control FSM
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       memReady = 1'b0;
    logic       pcWrite, branch, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSrc;
    logic       illegalOp, memTimeout;
    logic [3:0] state;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [17:0] outs;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    multicycle_control_unit #(.WAIT_TIMEOUT(15), .ALUOP_W(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .branch(branch), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSrc(pcSrc), .illegalOp(illegalOp), .memTimeout(memTimeout), .state(state)
    );

    always #5 clk = ~clk;

    // Per-state output table, order:
    // {pcWrite,branch,iorD,memRead,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,aluSrcB,aluOp,pcSrc,illegalOp,memTimeout}
    function automatic logic [17:0] specOut(logic [3:0] st, logic rdy, logic ill, logic tmo);
        logic pw, br, id, mr, mw, iw, rd, mt, rw, aa;
        logic [1:0] ab, ao, ps;
        {pw, br, id, mr, mw, iw, rd, mt, rw, aa} = '0;
        ab = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0: begin mr = 1; ab = 2'b01; iw = rdy; pw = rdy; end
            4'd1: ab = 2'b11;
            4'd2: begin aa = 1; ab = 2'b10; end
            4'd3: begin mr = 1; id = 1; end
            4'd4: begin mt = 1; rw = 1; end
            4'd5: begin mw = 1; id = 1; end
            4'd6: begin aa = 1; ao = 2'b10; end
            4'd7: begin rd = 1; rw = 1; end
            4'd8: begin aa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            4'd9: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {pw, br, id, mr, mw, iw, rd, mt, rw, aa, ab, ao, ps, ill, tmo};
    endfunction

    task automatic step(input string n, input logic r, input logic rdy, input logic [5:0] op,
                        input logic [3:0] st, input logic ill, input logic tmo);
        exp_t e;
        reset    = r;
        memReady = rdy;
        opcode   = op;
        e.name = n;
        e.st   = st;
        e.outs = specOut(st, rdy, ill, tmo);
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = expQ.pop_front();
            act = {pcWrite, branch, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite,
                   aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp, memTimeout};
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s state: got %0d expected %0d", e.name, state, e.st);
            end
            checks++;
            if (act !== e.outs) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", e.name, act, e.outs);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step("reset_hold", 1, 0, LW, 0, 0, 0);
        step("reset_rel", 0, 0, LW, 0, 0, 0);
        // lw interrupted by reset while waiting in MEMRD
        step("lwr_f", 0, 1, LW, 0, 0, 0);
        step("lwr_d", 0, 1, LW, 1, 0, 0);
        step("lwr_ma", 0, 1, LW, 2, 0, 0);
        step("lwr_mrd", 0, 0, LW, 3, 0, 0);
        step("lwr_async", 1, 0, LW, 0, 0, 0);
        step("lwr_after", 0, 0, LW, 0, 0, 0);
        // lw with memReady tied high
        step("lw_f", 0, 1, LW, 0, 0, 0);
        step("lw_d", 0, 1, LW, 1, 0, 0);
        step("lw_ma", 0, 1, LW, 2, 0, 0);
        step("lw_mrd", 0, 1, LW, 3, 0, 0);
        step("lw_wb", 0, 1, LW, 4, 0, 0);
        // R-type with a 3-cycle fetch stall
        for (int i = 0; i < 3; i++) step("rt_stall", 0, 0, RT, 0, 0, 0);
        step("rt_f", 0, 1, RT, 0, 0, 0);
        step("rt_d", 0, 1, RT, 1, 0, 0);
        step("rt_ex", 0, 1, RT, 6, 0, 0);
        step("rt_wb", 0, 1, RT, 7, 0, 0);
        // sw aborted after 15 wait cycles in MEMWR
        step("swt_f", 0, 1, SW, 0, 0, 0);
        step("swt_d", 0, 1, SW, 1, 0, 0);
        step("swt_ma", 0, 1, SW, 2, 0, 0);
        for (int i = 0; i < 15; i++) step("swt_wait", 0, 0, SW, 5, 0, 0);
        step("swt_tmo", 0, 0, SW, 5, 0, 1);
        // lw where memReady arrives exactly at the timeout boundary
        step("lwb_f", 0, 1, LW, 0, 0, 0);
        step("lwb_d", 0, 1, LW, 1, 0, 0);
        step("lwb_ma", 0, 1, LW, 2, 0, 0);
        for (int i = 0; i < 15; i++) step("lwb_wait", 0, 0, LW, 3, 0, 0);
        step("lwb_ready", 0, 1, LW, 3, 0, 0);
        step("lwb_wb", 0, 1, LW, 4, 0, 0);
        // beq
        step("beq_f", 0, 1, BEQ, 0, 0, 0);
        step("beq_d", 0, 1, BEQ, 1, 0, 0);
        step("beq_br", 0, 1, BEQ, 8, 0, 0);
        // j
        step("j_f", 0, 1, JMP, 0, 0, 0);
`ifdef MCU_JUMP_EN
        step("j_d", 0, 1, JMP, 1, 0, 0);
        step("j_jump", 0, 1, JMP, 9, 0, 0);
`else
        step("j_illegal", 0, 1, JMP, 1, 1, 0);
`endif
        // unsupported opcode
        step("bad_f", 0, 1, BAD, 0, 0, 0);
        step("bad_d", 0, 1, BAD, 1, 1, 0);
        // fetch timeout restarts fetch without loading IR/PC
        for (int i = 0; i < 15; i++) step("ft_wait", 0, 0, SW, 0, 0, 0);
        step("ft_tmo", 0, 0, SW, 0, 0, 1);
        step("ft_f", 0, 1, SW, 0, 0, 0);
        step("sw_d", 0, 1, SW, 1, 0, 0);
        step("sw_ma", 0, 1, SW, 2, 0, 0);
        step("sw_mwr", 0, 1, SW, 5, 0, 0);
        step("sw_done", 0, 0, SW, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation control unit for the MIPS core: a multicycle FSM replacing the single-cycle opcode decoder.
- Sequences fetch, decode, execute, memory and writeback over several cycles and drives datapath enables per state.
- Supports variable-latency memory through a ready handshake with a bounded wait timeout.
- Sits between the instruction register opcode field and the shared ALU/memory/register-file datapath.

Parameters:
- WAIT_TIMEOUT, 15: maximum cycles spent waiting on memReady in a memory state before abort; 0 disables the timeout.
- ALUOP_W, 2: width of aluOp. Encodings: 00 = add, 01 = sub, 10 = funct-decoded. Upper bits are zero when ALUOP_W > 2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instruction-register opcode field [31:26]
- memReady  in  1  memory completes the current read/write this cycle
- pcWrite  out  1  unconditional PC load
- branch  out  1  conditional PC load; datapath ANDs it with ALU zero
- iorD  out  1  memory address source: 0 = PC, 1 = ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction-register load
- regDst  out  1  register write destination: 1 = rd, 0 = rt
- memToReg  out  1  writeback data source: 1 = memory data register, 0 = ALUOut
- regWrite  out  1  register-file write enable
- aluSrcA  out  1  ALU A input: 0 = PC, 1 = register A
- aluSrcB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- aluOp  out  ALUOP_W  ALU control class
- pcSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegalOp  out  1  one-cycle pulse when an unsupported opcode is decoded
- memTimeout  out  1  one-cycle pulse when a memory wait is aborted
- state  out  4  current state, for debug

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9. Codes 10–15 are unreachable; if entered, the next state is FETCH.
- Reset (asynchronous): state = FETCH and wait counter = 0. All outputs take their FETCH values with memReady = 0, so memRead = 1 and all other enables = 0. Reset asserted mid-instruction drops to FETCH immediately; no writes complete afterwards.
- Outputs are combinational from state. The only exceptions are irWrite, pcWrite (in FETCH), illegalOp and memTimeout, which are additionally qualified by inputs as stated below. Any signal not listed for a state is 0.
- FETCH:
  - Outputs: memRead = 1, iorD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = add, pcSrc = 00, irWrite = pcWrite = memReady.
  - Transition: to DECODE when memReady = 1; otherwise hold.
- DECODE:
  - Outputs: aluSrcA = 0, aluSrcB = 11, aluOp = add.
  - Next state by opcode: 100011 (lw) and 101011 (sw) → MEMADR; 000000 (R-type) → EXEC; 000100 (beq) → BRANCH; 000010 (j) → JUMP, only when the optional feature is enabled.
  - Any other opcode → FETCH, with illegalOp = 1 for this cycle.
- MEMADR:
  - Outputs: aluSrcA = 1, aluSrcB = 10, aluOp = add.
  - Transition: to MEMRD if the opcode is lw, else to MEMWR. The opcode is stable because the IR is held.
- MEMRD:
  - Outputs: memRead = 1, iorD = 1.
  - Transition: to MEMWB on memReady; otherwise hold.
- MEMWB:
  - Outputs: regDst = 0, memToReg = 1, regWrite = 1.
  - Transition: to FETCH.
- MEMWR:
  - Outputs: memWrite = 1, iorD = 1.
  - Transition: to FETCH on memReady; otherwise hold.
- EXEC:
  - Outputs: aluSrcA = 1, aluSrcB = 00, aluOp = funct-decoded.
  - Transition: to ALUWB.
- ALUWB:
  - Outputs: regDst = 1, memToReg = 0, regWrite = 1.
  - Transition: to FETCH.
- BRANCH:
  - Outputs: aluSrcA = 1, aluSrcB = 00, aluOp = sub, pcSrc = 01, branch = 1.
  - Transition: to FETCH.
- JUMP:
  - Outputs: pcSrc = 10, pcWrite = 1.
  - Transition: to FETCH.
- Wait counter (applies in FETCH, MEMRD and MEMWR):
  - Width is the ceiling of log2(WAIT_TIMEOUT + 1).
  - Clears on every state change and whenever memReady = 1; otherwise increments each cycle in the wait state, saturating at WAIT_TIMEOUT.
  - If WAIT_TIMEOUT > 0, the counter equals WAIT_TIMEOUT and memReady = 0: memTimeout = 1 for that cycle, next state = FETCH, and the counter clears.
  - In FETCH this restarts the fetch; irWrite and pcWrite stay 0.
  - memReady = 1 in the same cycle as the timeout condition wins: normal completion, no memTimeout.
- Latency with memReady tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles

Optional Feature:
- Macro: MCU_JUMP_EN.
- When defined: opcode 000010 decodes to JUMP, which drives pcSrc = 10 and pcWrite = 1 for one cycle, then returns to FETCH.
- When undefined: the JUMP state and pcSrc = 10 are never produced. Opcode 000010 is treated as illegal: illegalOp pulses in DECODE and the next state is FETCH.

Test Plan:
- Reset while in MEMRD → on the same cycle state = 0 and memRead = 1; regWrite is never asserted afterwards.
- memReady = 1, opcode = 100011 → state sequence 0,1,2,3,4,0; regWrite = 1 and memToReg = 1 only in state 4; irWrite is high for exactly 1 cycle.
- opcode = 000000, memReady held 0 for 3 cycles in FETCH, then 1 → 3 hold cycles with irWrite = 0, then sequence 1,6,7,0 with aluOp = 10 in state 6 and regDst = 1 in state 7.
- opcode = 101011, memReady held 0 in MEMWR with WAIT_TIMEOUT = 15 → memTimeout pulses once, 15 cycles after entering MEMWR; next state = 0; memWrite = 1 for all 16 cycles in MEMWR.
- opcode = 000100 → DECODE then BRANCH with branch = 1, pcSrc = 01 and aluOp = 01, back in FETCH after 3 cycles total.
- opcode = 000010 → with MCU_JUMP_EN: pcWrite = 1 and pcSrc = 10 in state 9; without it: illegalOp = 1 in DECODE and next state = 0.
